// File: rtl/game_status.sv
// Round controller for the guessing game: qualifies guesses, tracks lives and
// guess count, and sequences a round through IDLE, PLAY, WON and LOST.
module game_status #(
    parameter int MAX_LIVES = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        load,
    input  logic [4:0]  load_x,
    input  logic [25:0] current_mask,
    input  logic        win,
    input  logic        wrong,
    output logic        fwd_load,
    output logic [4:0]  fwd_x,
    output logic        round_clear,
    output logic [1:0]  state,
    output logic [3:0]  lives_left,
    output logic [7:0]  guess_count,
    output logic        repeat_guess,
    output logic        bad_guess,
    output logic        busy_drop
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WON  = 2'b10,
        ST_LOST = 2'b11
    } state_t;

    // Pipeline phase names the edge that comes next for a forwarded guess.
    typedef enum logic [1:0] {
        PH_FREE  = 2'b00,
        PH_ISSUE = 2'b01,
        PH_EVAL  = 2'b10
    } phase_t;

    localparam logic [3:0] LIVES_INIT = 4'(MAX_LIVES);
    localparam logic [4:0] LAST_LETTER = 5'd25;

    state_t      state_r;
    phase_t      phase_r;
    logic [3:0]  lives_r;
    logic [7:0]  count_r;
    logic        fwd_load_r;
    logic [4:0]  fwd_x_r;
    logic        round_clear_r;
    logic        repeat_r;
    logic        bad_r;
    logic        drop_r;

    logic        in_play_s;
    logic        busy_s;
    logic        x_valid_s;
    logic        x_seen_s;
    logic [31:0] mask_ext_s;
    logic        accept_s;
    logic        bad_s;
    logic        repeat_s;
    logic        drop_s;
    logic        miss_s;
    logic        win_ok_s;
    logic [3:0]  lives_next_s;

    // Guess qualification and evaluate-edge arithmetic.
    always_comb begin
        in_play_s  = (state_r == ST_PLAY);
        busy_s     = (phase_r != PH_FREE);
        x_valid_s  = (load_x <= LAST_LETTER);
        mask_ext_s = {6'd0, current_mask};
        if (x_valid_s) begin
            x_seen_s = mask_ext_s[load_x];
        end else begin
            x_seen_s = 1'b0;
        end
        win_ok_s = in_play_s && win && (phase_r != PH_ISSUE);
        bad_s    = in_play_s && load && !busy_s && !x_valid_s;
        repeat_s = in_play_s && load && !busy_s && x_valid_s && x_seen_s;
        accept_s = in_play_s && load && !busy_s && x_valid_s && !x_seen_s && !win;
        drop_s   = in_play_s && load && busy_s;
        miss_s   = (phase_r == PH_EVAL) && wrong && (lives_r != 4'd0);
        if (miss_s) begin
            lives_next_s = lives_r - 4'd1;
        end else begin
            lives_next_s = lives_r;
        end
    end

    // Round state machine, guess pipeline and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            phase_r       <= PH_FREE;
            lives_r       <= LIVES_INIT;
            count_r       <= 8'd0;
            fwd_load_r    <= 1'b0;
            fwd_x_r       <= 5'd0;
            round_clear_r <= 1'b0;
            repeat_r      <= 1'b0;
            bad_r         <= 1'b0;
            drop_r        <= 1'b0;
        end else begin
            fwd_load_r    <= 1'b0;
            round_clear_r <= 1'b0;
            repeat_r      <= bad_s ? 1'b0 : repeat_s;
            bad_r         <= bad_s;
            drop_r        <= drop_s;
            case (state_r)
                ST_IDLE, ST_WON, ST_LOST: begin
                    if (start) begin
                        state_r       <= ST_PLAY;
                        phase_r       <= PH_FREE;
                        lives_r       <= LIVES_INIT;
                        count_r       <= 8'd0;
                        round_clear_r <= 1'b1;
                    end else begin
                        phase_r <= PH_FREE;
                    end
                end
                ST_PLAY: begin
                    case (phase_r)
                        PH_FREE: begin
                            if (win_ok_s) begin
                                state_r <= ST_WON;
                            end else if (accept_s) begin
                                fwd_load_r <= 1'b1;
                                fwd_x_r    <= load_x;
                                phase_r    <= PH_ISSUE;
                            end else begin
                                phase_r <= PH_FREE;
                            end
                        end
                        PH_ISSUE: begin
                            phase_r <= PH_EVAL;
                            if (count_r != 8'hFF) begin
                                count_r <= count_r + 8'd1;
                            end else begin
                                count_r <= count_r;
                            end
                        end
                        PH_EVAL: begin
                            phase_r <= PH_FREE;
                            lives_r <= lives_next_s;
                            // A win on the evaluate edge outranks running out of lives.
                            if (win_ok_s) begin
                                state_r <= ST_WON;
                            end else if (lives_next_s == 4'd0) begin
                                state_r <= ST_LOST;
                            end else begin
                                state_r <= ST_PLAY;
                            end
                        end
                        default: phase_r <= PH_FREE;
                    endcase
                end
                default: begin
                    state_r <= ST_IDLE;
                    phase_r <= PH_FREE;
                end
            endcase
        end
    end

    assign state        = state_r;
    assign lives_left   = lives_r;
    assign guess_count  = count_r;
    assign fwd_load     = fwd_load_r;
    assign fwd_x        = fwd_x_r;
    assign round_clear  = round_clear_r;
    assign repeat_guess = repeat_r;
    assign bad_guess    = bad_r;
    assign busy_drop    = drop_r;

endmodule
